// File: rtl/seq_pattern_gen.sv
// seq_pattern_gen: serial pattern transmitter for exercising sequence detectors.
// Loads a WIDTH-bit pattern on start and shifts it out MSB-first, optionally
// repeating it back-to-back, while counting the 1->0 transitions it emits.
//
// state | meaning
// IDLE  | waiting for start, outputs quiet
// SHIFT | driving one pattern bit per clock
// FIN   | one-cycle done pulse, start ignored
module seq_pattern_gen #(
   parameter int WIDTH  = 8,
   parameter int CNT_W  = 4,
   parameter int DCNT_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [WIDTH-1:0]  pattern,
   input  logic [CNT_W-1:0]  repeat_n,
   output logic              x_out,
   output logic              bit_valid,
   output logic              busy,
   output logic              done,
   output logic [DCNT_W-1:0] det_count
);

   localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, SHIFT, FIN} state_t;

   state_t             state;
   logic [WIDTH-1:0]   shadow;
   logic [IDX_W-1:0]   idx;
   logic [CNT_W-1:0]   pass_cnt;
   logic               next_bit;
   logic               more_bits;

   // Bit that the next SHIFT edge would drive; wraps to the MSB between passes.
   always_comb begin
      next_bit  = 1'b0;
      more_bits = (idx != '0) || (pass_cnt != '0);
      if (idx != '0)
         next_bit = shadow[idx - IDX_W'(1)];
      else if (pass_cnt != '0)
         next_bit = shadow[WIDTH-1];
   end

   // Sequencer: loads shadows on start, shifts bits, counts 1->0 transitions.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         shadow    <= '0;
         idx       <= '0;
         pass_cnt  <= '0;
         x_out     <= 1'b0;
         bit_valid <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         det_count <= '0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  shadow    <= pattern;
                  pass_cnt  <= repeat_n;
                  idx       <= LAST_IDX;
                  det_count <= '0;
                  x_out     <= pattern[WIDTH-1];
                  bit_valid <= 1'b1;
                  busy      <= 1'b1;
                  state     <= SHIFT;
               end else begin
                  x_out     <= 1'b0;
                  bit_valid <= 1'b0;
                  busy      <= 1'b0;
               end
            end
            SHIFT: begin
               if (more_bits) begin
                  x_out <= next_bit;
                  if (idx != '0) begin
                     idx <= idx - IDX_W'(1);
                  end else begin
                     idx      <= LAST_IDX;
                     pass_cnt <= pass_cnt - CNT_W'(1);
                  end
                  // x_out still holds the previous valid bit of this transfer
                  if (x_out && !next_bit && (det_count != '1))
                     det_count <= det_count + DCNT_W'(1);
               end else begin
                  x_out     <= 1'b0;
                  bit_valid <= 1'b0;
                  busy      <= 1'b0;
                  done      <= 1'b1;
                  state     <= FIN;
               end
            end
            FIN: begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               state     <= IDLE;
               x_out     <= 1'b0;
               bit_valid <= 1'b0;
               busy      <= 1'b0;
               done      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/seq_pattern_gen.md
Name: seq_pattern_gen

Overview:
Serial bit-stream transmitter that pairs with the team's serial sequence-detector FSMs. It loads a WIDTH-bit pattern on a start strobe and shifts it out MSB-first, one bit per clock. The pattern can be repeated back-to-back a programmable number of times. It also counts the "1 then 0" transitions it emits, so a bench can check the detector's pulse count against an expected value.

Parameters:
WIDTH, 8, pattern length in bits (>=2)
CNT_W, 4, width of the repeat-count input
DCNT_W, 8, width of the saturating transition counter

Ports:
clk  input  1  system clock, rising-edge active
reset  input  1  asynchronous, active-low reset
start  input  1  request to begin a transfer; sampled only in IDLE
pattern  input  WIDTH  bits to transmit; bit WIDTH-1 goes first
repeat_n  input  CNT_W  extra passes; 0 = send once, N = send N+1 times
x_out  output  1  serial data bit (feeds a detector's x_in)
bit_valid  output  1  x_out carries a pattern bit this cycle
busy  output  1  transfer in progress
done  output  1  one-cycle pulse after the last bit
det_count  output  DCNT_W  number of 1->0 transitions emitted in the current or last transfer

Behaviour:
- Reset (reset=0, asynchronous, acts immediately, including mid-transfer):
  - state goes to IDLE
  - x_out, bit_valid, busy, done, det_count all 0
  - internal shadow registers, bit index, pass counter and prev-bit register all 0
- All other state changes happen on the rising edge of clk. All outputs are registered.
- States: IDLE, SHIFT, FIN.
- IDLE:
  - x_out=0, bit_valid=0, busy=0.
  - On an edge with start=1:
    - capture pattern into the shadow register and repeat_n into the pass counter
    - set bit index to WIDTH-1, clear det_count and prev-bit
    - drive x_out<=pattern[WIDTH-1], bit_valid<=1, busy<=1
    - go to SHIFT
  - Latency: the first bit is visible the cycle after the start edge.
- SHIFT: each edge advances one bit.
  - If index>0: index decrements and x_out<=shadow[index-1].
  - If index==0 and pass counter>0: counter decrements, index reloads to WIDTH-1, x_out<=shadow[WIDTH-1]. There is no gap cycle between passes.
  - If index==0 and pass counter==0: x_out<=0, bit_valid<=0, busy<=0, done<=1, go to FIN.
- FIN: done returns to 0 on the next edge and the state goes to IDLE. A start in the FIN cycle is ignored.
- Total bit_valid cycles per transfer = WIDTH*(repeat_n+1), contiguous.
- det_count:
  - Increments by 1 on each edge where the newly driven bit is 0 and the previously driven valid bit of the same transfer is 1.
  - Pass boundaries count (a pass ending in 1 followed by a pass starting with 0 adds 1).
  - The first bit of a transfer never counts.
  - Saturates at all-ones.
  - Holds its value after done until the next accepted start.
- start while busy (SHIFT or FIN) is ignored. pattern and repeat_n changes during a transfer have no effect, since the shadow copies are used.
- A start held high continuously begins a new transfer in each IDLE cycle reached. The minimum spacing between transfers is WIDTH*(repeat_n+1)+2 cycles.

Test Plan:
- Reset low 3 cycles, release; WIDTH=8, pattern=8'b1010_0110, repeat_n=0, start pulse:
  - x_out = 1,0,1,0,0,1,1,0 on 8 consecutive cycles with bit_valid=1
  - done=1 on cycle 9, busy low; det_count=3
- pattern=8'b0000_0001, repeat_n=1:
  - 16 contiguous valid bits, last bit of pass 1 is 1, first of pass 2 is 0
  - det_count=1, done after 16 bits
- pattern=8'hAA, repeat_n=0; then pulse start and change pattern to 8'h00 at bit 3:
  - transmitted stream unchanged (1,0,1,0,1,0,1,0); second start ignored; det_count=4
- Assert reset=0 asynchronously (between clock edges) at bit 5 of an 8'hF0 transfer:
  - outputs go to 0 before the next edge
  - after release, next start with pattern=8'h81 transmits cleanly; det_count=1
- DCNT_W=4, pattern=8'hAA, repeat_n=3:
  - 32 bits, 16 transitions; det_count saturates at 4'hF and holds after done
- pattern=8'hFF, repeat_n=15: 128 valid bits, det_count=0, single done pulse at cycle 129.
